// File: rtl/div_seq_param.sv
// div_seq_param: radix-2 restoring sequential divider.
// Fixed latency of W+1 edges from capture to ack (one edge for divide-by-zero),
// signed or unsigned selected per operation, quotient truncates toward zero.
module div_seq_param #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         ack,
    output logic         busy,
    output logic         div0
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Two's-complement negate when neg is set; the most-negative value maps to
    // itself, which read as unsigned is the magnitude 2^(W-1).
    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            div0_q, div0_d;

    // Iteration datapath: p holds the partial remainder, a shifts the dividend
    // out at the top while quotient bits shift in at the bottom.
    logic [W:0]      p_q, p_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            bz_q, bz_d;

    logic [W:0]      shift_p;
    logic [W:0]      diff;

    assign Q    = q_q;
    assign R    = r_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign div0 = div0_q;

    // Next-state, datapath step and output updates.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        div0_d  = div0_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bz_d    = bz_q;
        shift_p = {p_q[W-1:0], a_q[W-1]};
        diff    = shift_p - {1'b0, b_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    qneg_d = sgn & (A[W-1] ^ B[W-1]);
                    rneg_d = sgn & A[W-1];
                    b_d    = cond_neg(B, sgn & B[W-1]);
                    bz_d   = (B == '0);
                    p_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (B == '0) begin
                        // Keep the raw dividend so it can be returned as R.
                        a_d     = A;
                        state_d = FIX;
                    end else begin
                        a_d     = cond_neg(A, sgn & A[W-1]);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[W]) begin
                    p_d = diff;
                    a_d = {a_q[W-2:0], 1'b1};
                end else begin
                    p_d = shift_p;
                    a_d = {a_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (bz_q) begin
                    q_d    = '1;
                    r_d    = a_q;
                    div0_d = 1'b1;
                end else begin
                    q_d    = cond_neg(a_q, qneg_q);
                    r_d    = cond_neg(p_q[W-1:0], rneg_q);
                    div0_d = 1'b0;
                end
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers; reset wins over any operation in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            div0_q  <= div0_d;
        end
    end

    // Working registers; always reloaded at capture, so no reset needed.
    always_ff @(posedge Clk) begin
        p_q    <= p_d;
        a_q    <= a_d;
        b_q    <= b_d;
        cnt_q  <= cnt_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
        bz_q   <= bz_d;
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: directed table, hand-written corner sequences and
// randomized operations at W=16 and W=8 against an arithmetic reference.
module tb_div_seq_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        st16, sg16, ack16, busy16, z16;
    logic [15:0] a16, b16, q16, r16;
    logic        st8, sg8, ack8, busy8, z8;
    logic [7:0]  a8, b8, q8, r8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_seq_param #(.W(16)) dut16 (
        .Clk(clk), .Rst(rst), .start(st16), .sgn(sg16), .A(a16), .B(b16),
        .Q(q16), .R(r16), .ack(ack16), .busy(busy16), .div0(z16)
    );

    div_seq_param #(.W(8)) dut8 (
        .Clk(clk), .Rst(rst), .start(st8), .sgn(sg8), .A(a8), .B(b8),
        .Q(q8), .R(r8), .ack(ack8), .busy(busy8), .div0(z8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division of the operands as numbers of width w.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic s, output logic [15:0] q,
                                  output logic [15:0] r, output logic z);
        longint mask, sa, sb;
        mask = (longint'(1) << w) - 1;
        if (b == 16'd0) begin
            q = 16'(mask);
            r = a;
            z = 1'b1;
            return;
        end
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        q = 16'((sa / sb) & mask);
        r = 16'((sa % sb) & mask);
        z = 1'b0;
    endfunction

    function automatic logic [15:0] q_of(input int w);
        return (w == 16) ? q16 : {8'h00, q8};
    endfunction
    function automatic logic [15:0] r_of(input int w);
        return (w == 16) ? r16 : {8'h00, r8};
    endfunction
    function automatic logic ack_of(input int w);
        return (w == 16) ? ack16 : ack8;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 16) ? busy16 : busy8;
    endfunction
    function automatic logic z_of(input int w);
        return (w == 16) ? z16 : z8;
    endfunction

    // One start pulse, then scramble the inputs and wait for ack.
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input string nm);
        int n;
        if (w == 16) begin
            a16 = a; b16 = b; sg16 = s; st16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; sg8 = s; st8 = 1'b1;
        end
        tick();
        st16 = 1'b0; st8 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1'($urandom);
        a8  = 8'($urandom);  b8  = 8'($urandom);  sg8  = 1'($urandom);
        check({nm, " busy"}, 64'(busy_of(w)), 64'd1);
        n = 0;
        while (!ack_of(w) && n < 100) begin
            tick();
            n++;
        end
        check({nm, " latency"}, 64'(n), (b == 16'd0) ? 64'd1 : 64'(w + 1));
        check({nm, " Q"}, 64'(q_of(w)), 64'(eq));
        check({nm, " R"}, 64'(r_of(w)), 64'(er));
        check({nm, " div0"}, 64'(z_of(w)), 64'(ez));
        tick();
        check({nm, " ack pulse"}, 64'({ack_of(w), busy_of(w)}), 64'd0);
    endtask

    initial begin
        vec_t        vt[$];
        logic [15:0] eq, er, ra, rb;
        logic        ez, rs;
        int          acks, t1, t2, ack_seen;
        logic [15:0] q1, r1, q2, r2;

        vt.push_back('{16'd7,    16'd2,    1'b0, 16'd3,    16'd1,    1'b0});
        vt.push_back('{16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0});
        vt.push_back('{16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0});
        vt.push_back('{16'd5,    16'd0,    1'b0, 16'hFFFF, 16'd5,    1'b1});
        vt.push_back('{16'd7,    16'd2,    1'b0, 16'd3,    16'd1,    1'b0});
        vt.push_back('{16'hFFFF, 16'd1,    1'b0, 16'hFFFF, 16'd0,    1'b0});
        vt.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0,    1'b0});
        vt.push_back('{16'd3,    16'd10,   1'b0, 16'd0,    16'd3,    1'b0});
        vt.push_back('{16'hFFF9, 16'd0,    1'b1, 16'hFFFF, 16'hFFF9, 1'b1});
        vt.push_back('{16'h8000, 16'd1,    1'b1, 16'h8000, 16'd0,    1'b0});
        vt.push_back('{16'h8001, 16'd2,    1'b1, 16'hC001, 16'hFFFF, 1'b0});

        rst = 1'b1;
        st16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
        st8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset 16", {q16, r16, 13'd0, ack16, busy16, z16}, 64'd0);
        check("reset 8",  {q8, r8, 13'd0, ack8, busy8, z8}, 64'd0);

        foreach (vt[i]) begin
            do_op(16, vt[i].a, vt[i].b, vt[i].s, vt[i].q, vt[i].r, vt[i].z,
                  $sformatf("vec%0d", i));
        end

        // Reset in the middle of a divide: no ack, outputs cleared.
        a16 = 16'd100; b16 = 16'd7; sg16 = 1'b0; st16 = 1'b1;
        tick();
        st16 = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst outputs", {q16, r16, 13'd0, ack16, busy16, z16}, 64'd0);
        ack_seen = 0;
        repeat (30) begin
            tick();
            if (ack16) ack_seen++;
        end
        check("midrst no ack", 64'(ack_seen), 64'd0);
        do_op(16, 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, "after rst");

        // start held high: two captures, A/B scrambled while the first computes.
        a16 = 16'd1000; b16 = 16'd3; sg16 = 1'b0; st16 = 1'b1;
        tick();
        acks = 0; t1 = 0; t2 = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 60 && acks < 2; c++) begin
            if (c >= 17) begin
                a16 = 16'd500; b16 = 16'd7;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom);
            end
            tick();
            if (ack16) begin
                acks++;
                if (acks == 1) begin
                    t1 = c; q1 = q16; r1 = r16;
                end else begin
                    t2 = c; q2 = q16; r2 = r16; st16 = 1'b0;
                end
            end
        end
        st16 = 1'b0;
        tick();
        check("b2b ack count", 64'(acks), 64'd2);
        check("b2b first ack edge", 64'(t1), 64'd17);
        check("b2b ack spacing", 64'(t2 - t1), 64'd19);
        check("b2b first Q/R", {32'd0, q1, r1}, {32'd0, 16'd333, 16'd1});
        check("b2b second Q/R", {32'd0, q2, r2}, {32'd0, 16'd71, 16'd3});
        check("b2b idle", 64'({ack16, busy16}), 64'd0);

        do_op(8, 16'd200, 16'd9, 1'b0, 16'd22, 16'd2, 1'b0, "w8 200/9");
        do_op(8, 16'h80, 16'hFF, 1'b1, 16'h80, 16'd0, 1'b0, "w8 ovf");

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rs = 1'($urandom);
            case ($urandom % 4)
                0: rb = 16'd0;
                1: rb = 16'($urandom_range(1, 20));
                2: rb = -16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            model(16, ra, rb, rs, eq, er, ez);
            do_op(16, ra, rb, rs, eq, er, ez, $sformatf("rnd16_%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = ($urandom % 5 == 0) ? 16'd0 : 16'($urandom_range(1, 255));
            rs = 1'($urandom);
            model(8, ra, rb, rs, eq, er, ez);
            do_op(8, ra, rb, rs, eq, er, ez, $sformatf("rnd8_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
